fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage feeding ctrl_unit: owns the PC, reads instruction words from program memory via a req/valid handshake, holds them in the IR.
//  Drives opcode = ir[15:11] to ctrl_unit; fetch/jump requests come from ctrl_unit signals.
//  One fetch in flight at a time; the microprogram fetch state waits on fetch_done.
// PARAMETERS
//  INSTR_WIDTH  16   instruction word width; opcode is always ir[INSTR_WIDTH-1:INSTR_WIDTH-5]
//  PC_WIDTH     8    program counter / program memory address width
//  RESET_PC     0    PC value loaded on reset
// PORTS
//  clk        in   1            system clock, all state on posedge
//  rst        in   1            asynchronous, active-high reset
//  fetch_go   in   1            request one instruction fetch at current PC (level sampled per cycle)
//  jmp_en     in   1            load PC from jmp_addr
//  jmp_addr   in   PC_WIDTH     jump target
//  mem_addr   out  PC_WIDTH     program memory address, valid while mem_req=1
//  mem_req    out  1            read request to program memory
//  mem_data   in   INSTR_WIDTH  read data, valid when mem_valid=1
//  mem_valid  in   1            read data valid (any latency >= 1 cycle after mem_req rises)
//  ir         out  INSTR_WIDTH  instruction register
//  opcode     out  5            ir[INSTR_WIDTH-1 -: 5], combinational from ir
//  pc         out  PC_WIDTH     current program counter
//  ir_valid   out  1            ir holds a fetched instruction
//  fetch_done out  1            one-cycle pulse when ir is loaded
//  busy       out  1            1 while in WAIT
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, ir=0, ir_valid=0, mem_req=0, fetch_done=0, jmp_pending=0; mem_addr=pc.
//  Reset mid-fetch aborts: mem_req drops immediately; a mem_valid arriving after reset deasserts is ignored in IDLE.
//  States: IDLE, WAIT.
//  IDLE: jmp_en=1 -> pc<=jmp_addr, stay IDLE (jump wins; fetch_go same cycle ignored).
//        else fetch_go=1 -> WAIT, mem_req<=1, ir_valid<=0, mem_addr<=pc.
//  WAIT: mem_req=1, mem_addr held stable at fetch PC; fetch_go ignored.
//        jmp_en=1 in WAIT -> jmp_pending<=1, jmp_target<=jmp_addr (latest wins).
//        mem_valid=1 -> ir<=mem_data, ir_valid<=1, fetch_done<=1 (next cycle, one cycle),
//          mem_req<=0, state<=IDLE; pc<=jmp_pending ? jmp_target : pc+1; jmp_pending<=0.
//        mem_valid and jmp_en same cycle -> that jmp_addr is the new pc (counts as pending).
//  Latency: fetch_go sampled at edge N -> mem_req high after N; mem_valid at edge M -> ir, pc, fetch_done updated after M.
//    Minimum fetch_go to fetch_done: 2 cycles.
//  PC arithmetic: modulo 2^PC_WIDTH; pc=2^PC_WIDTH-1 increments to 0, no flag.
//  mem_valid while IDLE: ignored, no state change.
//  ir holds its value until the next successful fetch; ir_valid=0 only during WAIT and after reset.
//  opcode decoding is ctrl_unit's responsibility; fetch_unit never inspects ir.
// TESTING
//  1 reset then fetch_go, mem returns 16'h3A5C after 1 cycle -> mem_addr=0, ir=16'h3A5C, opcode=5'b00111, pc=1, one fetch_done pulse.
//  2 memory latency 4 cycles -> mem_req high 4 cycles, mem_addr stable at 0, busy=1 throughout, ir_valid=0 until load.
//  3 jmp_en=1 jmp_addr=8'h40 with fetch_go in IDLE -> pc=8'h40, no mem_req; next fetch_go reads 0x40, pc becomes 0x41.
//  4 jmp_en jmp_addr=8'h10 during WAIT at pc=5 -> ir loaded from addr 5, pc=8'h10 (not 6) after fetch_done.
//  5 pc=8'hFF, fetch -> mem_addr=8'hFF, pc wraps to 8'h00 after completion.
//  6 assert rst in WAIT, then mem_valid after release -> mem_req=0 during rst, pc=RESET_PC, ir=0, ir_valid=0, no fetch_done.

Source files
------------

// File: rtl/mem_if.sv
// Program memory read port between the fetch unit and instruction memory.
//
// Handshake: the master raises req with addr and keeps both stable until
// the slave answers with valid=1 for exactly the cycle in which data holds
// the instruction word. At most one read is outstanding, and valid may come
// any number of cycles (>= 1) after req rises.
//
// Signals:
//   addr   master->slave  PC_WIDTH     read address, meaningful while req=1
//   req    master->slave  1            read request
//   data   slave->master  INSTR_WIDTH  read data, meaningful while valid=1
//   valid  slave->master  1            read data valid
interface mem_if #(
  parameter int INSTR_WIDTH = 16,
  parameter int PC_WIDTH    = 8
);
  logic [PC_WIDTH-1:0]    addr;
  logic                   req;
  logic [INSTR_WIDTH-1:0] data;
  logic                   valid;

  modport master (output addr, output req, input data, input valid);
  modport slave  (input addr, input req, output data, output valid);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues one program-memory read at a
// time and captures the returned word in the IR for ctrl_unit.
//
// Ports:
//   clk         system clock, all state on posedge
//   rst         asynchronous active-high reset
//   fetch_go    request a fetch at the current PC (ignored while busy)
//   jmp_en      load PC from jmp_addr (deferred until completion while busy)
//   jmp_addr    jump target
//   mem         mem_if master port (addr, req, data, valid)
//   ir          instruction register
//   opcode      ir[INSTR_WIDTH-1 -: 5]
//   pc          current program counter
//   ir_valid    ir holds a fetched instruction
//   fetch_done  one-cycle pulse when ir is loaded
//   busy        1 while a fetch is outstanding
//   dbg_state   current FSM state (0=IDLE, 1=WAIT)
module fetch_unit #(
  parameter int              INSTR_WIDTH = 16,
  parameter int              PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_go,
  input  logic                   jmp_en,
  input  logic [PC_WIDTH-1:0]    jmp_addr,
  mem_if.master                  mem,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [4:0]             opcode,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   ir_valid,
  output logic                   fetch_done,
  output logic                   busy,
  output logic                   dbg_state
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   ir_valid_q, ir_valid_d;
  logic                   done_q, done_d;
  logic                   jmp_pending_q, jmp_pending_d;
  logic [PC_WIDTH-1:0]    jmp_target_q, jmp_target_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      ir_valid_q    <= 1'b0;
      done_q        <= 1'b0;
      jmp_pending_q <= 1'b0;
      jmp_target_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      done_q        <= done_d;
      jmp_pending_q <= jmp_pending_d;
      jmp_target_q  <= jmp_target_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_valid_d    = ir_valid_q;
    done_d        = 1'b0;
    jmp_pending_d = jmp_pending_q;
    jmp_target_d  = jmp_target_q;

    unique case (state_q)
      IDLE: begin
        // A jump in IDLE wins over a same-cycle fetch request.
        if (jmp_en) begin
          pc_d = jmp_addr;
        end else if (fetch_go) begin
          state_d    = WAIT;
          ir_valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (jmp_en) begin
          jmp_pending_d = 1'b1;
          jmp_target_d  = jmp_addr;
        end
        if (mem.valid) begin
          state_d       = IDLE;
          ir_d          = mem.data;
          ir_valid_d    = 1'b1;
          done_d        = 1'b1;
          jmp_pending_d = 1'b0;
          // A jump arriving with the data counts as pending; it is newer
          // than any previously latched target.
          if (jmp_en)             pc_d = jmp_addr;
          else if (jmp_pending_q) pc_d = jmp_target_q;
          else                    pc_d = pc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The PC cannot change while WAIT (jumps are deferred), so it doubles as
  // the stable fetch address.
  assign mem.addr   = pc_q;
  assign mem.req    = (state_q == WAIT);
  assign busy       = (state_q == WAIT);
  assign dbg_state  = state_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign ir_valid   = ir_valid_q;
  assign fetch_done = done_q;
  assign opcode     = ir_q[INSTR_WIDTH-1 -: 5];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_go = 1'b0;
  logic        jmp_en = 1'b0;
  logic [7:0]  jmp_addr = 8'h00;
  logic [15:0] ir;
  logic [4:0]  opcode;
  logic [7:0]  pc;
  logic        ir_valid, fetch_done, busy, dbg_state;

  mem_if #(.INSTR_WIDTH(16), .PC_WIDTH(8)) mem ();

  fetch_unit #(.INSTR_WIDTH(16), .PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .fetch_go(fetch_go), .jmp_en(jmp_en),
    .jmp_addr(jmp_addr), .mem(mem.master), .ir(ir), .opcode(opcode),
    .pc(pc), .ir_valid(ir_valid), .fetch_done(fetch_done), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: every fetch_done pulse must match the next expected IR word
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (fetch_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_fetch_done", 32'(ir), 32'hFFFF_FFFF);
      end else begin
        chk("sb_ir", 32'(ir), 32'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic        go;
    logic        jen;
    logic [7:0]  jaddr;
    logic        mv;
    logic [15:0] mdata;
    logic        e_req;
    logic [7:0]  e_addr;
    logic [7:0]  e_pc;
    logic [15:0] e_ir;
    logic        e_irv;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic go, logic jen, logic [7:0] jaddr, logic mv,
                              logic [15:0] mdata, logic e_req, logic [7:0] e_addr,
                              logic [7:0] e_pc, logic [15:0] e_ir, logic e_irv,
                              logic e_done, logic e_busy);
    vec_t v;
    v.go = go; v.jen = jen; v.jaddr = jaddr; v.mv = mv; v.mdata = mdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_ir = e_ir;
    v.e_irv = e_irv; v.e_done = e_done; v.e_busy = e_busy;
    return v;
  endfunction

  // driver
  task automatic drive(input logic go, input logic jen, input logic [7:0] jaddr,
                       input logic mv, input logic [15:0] mdata);
    fetch_go  = go;
    jmp_en    = jen;
    jmp_addr  = jaddr;
    mem.valid = mv;
    mem.data  = mdata;
  endtask

  logic [15:0] op_tmp;

  initial begin
    mem.valid = 1'b0;
    mem.data  = 16'h0000;

    //          go jen jaddr  mv mdata     req addr   pc     ir        irv done busy
    vecs.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 8'h00, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h00, 8'h00, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 16'h3A5C, 0, 8'h01, 8'h01, 16'h3A5C, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0, 8'h01, 8'h01, 16'h3A5C, 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h01, 8'h01, 16'h3A5C, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h01, 8'h01, 16'h3A5C, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h01, 8'h01, 16'h3A5C, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h01, 8'h01, 16'h3A5C, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 16'h1234, 0, 8'h02, 8'h02, 16'h1234, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 16'hFFFF, 0, 8'h02, 8'h02, 16'h1234, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h40, 0, 16'h0000, 0, 8'h40, 8'h40, 16'h1234, 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h40, 8'h40, 16'h1234, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 16'hABCD, 0, 8'h41, 8'h41, 16'hABCD, 1, 1, 0));
    vecs.push_back(mk(0, 1, 8'h05, 0, 16'h0000, 0, 8'h05, 8'h05, 16'hABCD, 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h05, 8'h05, 16'hABCD, 0, 0, 1));
    vecs.push_back(mk(0, 1, 8'h10, 0, 16'h0000, 1, 8'h05, 8'h05, 16'hABCD, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 16'h5555, 0, 8'h10, 8'h10, 16'h5555, 1, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h10, 8'h10, 16'h5555, 0, 0, 1));
    vecs.push_back(mk(0, 1, 8'h22, 1, 16'h0F0F, 0, 8'h22, 8'h22, 16'h0F0F, 1, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'h22, 8'h22, 16'h0F0F, 0, 0, 1));
    vecs.push_back(mk(0, 1, 8'h30, 0, 16'h0000, 1, 8'h22, 8'h22, 16'h0F0F, 0, 0, 1));
    vecs.push_back(mk(0, 1, 8'h31, 0, 16'h0000, 1, 8'h22, 8'h22, 16'h0F0F, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 16'h7777, 0, 8'h31, 8'h31, 16'h7777, 1, 1, 0));
    vecs.push_back(mk(0, 1, 8'hFF, 0, 16'h0000, 0, 8'hFF, 8'hFF, 16'h7777, 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 1, 8'hFF, 8'hFF, 16'h7777, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 16'h8001, 0, 8'h00, 8'h00, 16'h8001, 1, 1, 0));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem.req), 32'h0);
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_ir", 32'(ir), 32'h0000);
    chk("rst_irv", 32'(ir_valid), 32'h0);
    chk("rst_done", 32'(fetch_done), 32'h0);
    chk("rst_addr", 32'(mem.addr), 32'h00);
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].go, vecs[i].jen, vecs[i].jaddr, vecs[i].mv, vecs[i].mdata);
      if (vecs[i].e_done) exp_q.push_back(vecs[i].e_ir);
      @(posedge clk);
      #1;
      op_tmp = vecs[i].e_ir;
      chk($sformatf("v%0d_req", i), 32'(mem.req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_addr", i), 32'(mem.addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
      chk($sformatf("v%0d_ir", i), 32'(ir), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(op_tmp[15:11]));
      chk($sformatf("v%0d_irv", i), 32'(ir_valid), 32'(vecs[i].e_irv));
      chk($sformatf("v%0d_done", i), 32'(fetch_done), 32'(vecs[i].e_done));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
    end

    // reset while a fetch is outstanding: req must drop at once
    @(negedge clk);
    drive(1, 0, 8'h00, 0, 16'h0000);
    @(posedge clk);
    #1;
    chk("abort_req_before", 32'(mem.req), 32'h1);
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 16'h0000);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_req", 32'(mem.req), 32'h0);
    chk("abort_pc", 32'(pc), 32'h00);
    chk("abort_ir", 32'(ir), 32'h0000);
    chk("abort_irv", 32'(ir_valid), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 8'h00, 1, 16'hBEEF);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("late_valid_req", 32'(mem.req), 32'h0);
      chk("late_valid_ir", 32'(ir), 32'h0000);
      chk("late_valid_irv", 32'(ir_valid), 32'h0);
      chk("late_valid_done", 32'(fetch_done), 32'h0);
      chk("late_valid_pc", 32'(pc), 32'h00);
    end

    // four-cycle memory latency from PC 0
    @(negedge clk);
    drive(1, 0, 8'h00, 0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("lat4_req", 32'(mem.req), 32'h1);
      chk("lat4_addr", 32'(mem.addr), 32'h00);
      chk("lat4_busy", 32'(busy), 32'h1);
      chk("lat4_irv", 32'(ir_valid), 32'h0);
      @(negedge clk);
      drive(0, 0, 8'h00, 0, 16'h0000);
    end
    drive(0, 0, 8'h00, 1, 16'hC3C3);
    exp_q.push_back(16'hC3C3);
    @(posedge clk);
    #1;
    chk("lat4_done", 32'(fetch_done), 32'h1);
    chk("lat4_ir", 32'(ir), 32'hC3C3);
    chk("lat4_pc", 32'(pc), 32'h01);
    chk("lat4_req_end", 32'(mem.req), 32'h0);
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 16'h0000);
    @(posedge clk);
    #1;
    chk("lat4_done_pulse", 32'(fetch_done), 32'h0);
    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
